lfsr_rng: RTL
=============

// Module: lfsr_rng
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random source with seed load, step enable,
//  zero-lockup recovery and a bounded-range draw port using req/resp handshakes.
//  Serves car spawn, lane and speed randomness in the top module; several
//  instances with distinct SEEDs give independent streams.
// PARAMETERS
//  WIDTH    16            LFSR width; supported 8,16,24,32 (others: elaboration error)
//  SEED     32'hACE1_00A5 reset seed; SEED_EFF = SEED[WIDTH-1:0], or 1 if that is 0
//  OUT_W    8             ranged output width; 1 <= OUT_W <= WIDTH
//  MAX_TRY  4             rejection attempts before fallback, >= 1
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  en         in   1      step the LFSR this cycle
//  seed_load  in   1      load seed_in into the LFSR this cycle
//  seed_in    in   WIDTH  seed value; 0 is replaced by SEED_EFF
//  rnd        out  WIDTH  current LFSR state, registered
//  lock_err   out  1      one-cycle pulse: all-zero state detected and recovered
//  req_valid  in   1      ranged draw request
//  req_ready  out  1      high only in IDLE
//  req_range  in   OUT_W  exclusive upper bound R; 0 means full 2^OUT_W
//  resp_valid out  1      ranged result valid, held until accepted
//  resp_ready in   1      consumer accepts result
//  resp_data  out  OUT_W  result in [0, R-1]
// BEHAVIOUR
//  Reset: rnd=SEED_EFF, lock_err=0, FSM=IDLE, req_ready=1, resp_valid=0, resp_data=0.
//  Taps (feedback into bit0, shift left, XOR of listed bits):
//   W8: 7,5,4,3   W16: 15,14,12,3   W24: 23,22,21,16   W32: 31,21,1,0 (maximal period).
//  Next-state priority per edge: 1) rnd==0 -> SEED_EFF, lock_err=1 for that cycle;
//   2) seed_load -> seed_in (0 -> SEED_EFF); 3) en or FSM==DRAW -> step; 4) hold.
//  FSM IDLE: req_ready=1; on req_valid: latch R, compute mask = smallest 2^k-1 >= R-1
//   (R==0: all ones, no rejection; R==1: mask 0), clear try counter, go DRAW.
//  FSM DRAW: req_ready=0; cand = rnd[OUT_W-1:0] & mask from the registered state.
//   cand < R (or R==0): resp_data=cand, go DONE. Else try++; on try==MAX_TRY-1
//   take fallback cand-R (always < R) and go DONE. LFSR steps every DRAW cycle.
//  FSM DONE: resp_valid=1, resp_data stable; on resp_ready go IDLE (resp_valid=0).
//   A new request is not accepted in the same cycle as resp_ready.
//  Latency: accept at edge E0; earliest resp_valid after E1; worst after E(MAX_TRY).
//  seed_load during DRAW is legal: next DRAW cycle evaluates the new state.
//  Changes to req_range after acceptance are ignored; reset mid-draw aborts to IDLE.
// TESTING
//  WIDTH=8,SEED=A5, en=1: rnd sequence A5,4A,95; returns to A5 after exactly 255 steps, never 00.
//  WIDTH=16, en=1 for 65535 cycles: rnd returns to SEED_EFF, no earlier repeat, lock_err never set.
//  seed_load=1, seed_in=0 -> rnd=SEED_EFF next cycle; seed_in=0x1234 with en=1 -> rnd=0x1234 (load wins).
//  Force rnd=0 -> next cycle rnd=SEED_EFF, lock_err high exactly one cycle.
//  req_range=6, 1000 draws: every resp_data in 0..5, all six values seen; R=1 -> always 0; R=0 -> rnd[7:0].
//  Hold resp_ready=0 for 5 cycles: resp_valid and resp_data stable, req_ready=0 throughout.

Source files
------------

// File: rtl/lfsr_rng.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_rng
//  Brief    : Fibonacci LFSR random source with seed load, zero-lockup
//             recovery and a rejection-sampled bounded-range draw port.
//  Revision : 1.0
// ============================================================================
module lfsr_rng #(
    parameter int          WIDTH   = 16,
    parameter logic [31:0] SEED    = 32'hACE1_00A5,
    parameter int          OUT_W   = 8,
    parameter int          MAX_TRY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] rnd,
    output logic             lock_err,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] req_range,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [OUT_W-1:0] resp_data
);

    localparam logic [WIDTH-1:0] c_seed_raw = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_seed_eff = (c_seed_raw == '0) ? WIDTH'(1) : c_seed_raw;
    localparam int               c_try_w    = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
    localparam logic [c_try_w-1:0] c_try_last = c_try_w'(MAX_TRY - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_draw = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [WIDTH-1:0]   r_rnd;
    logic               r_lock_err;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [OUT_W-1:0]   r_range;
    logic [OUT_W-1:0]   r_mask;
    logic [c_try_w-1:0] r_try;
    logic [OUT_W-1:0]   r_resp_data;
    logic [OUT_W-1:0]   w_mask_new;
    logic [OUT_W-1:0]   w_cand;
    logic               w_hit;
    logic               w_last;
    logic               w_fb;

    if ((OUT_W < 1) || (OUT_W > WIDTH)) begin : g_bad_out_w
        $error("lfsr_rng: OUT_W must be in 1..WIDTH");
    end
    if (MAX_TRY < 1) begin : g_bad_max_try
        $error("lfsr_rng: MAX_TRY must be >= 1");
    end

    if (WIDTH == 8) begin : g_w8
        assign w_fb = r_rnd[7] ^ r_rnd[5] ^ r_rnd[4] ^ r_rnd[3];
    end else if (WIDTH == 16) begin : g_w16
        assign w_fb = r_rnd[15] ^ r_rnd[14] ^ r_rnd[12] ^ r_rnd[3];
    end else if (WIDTH == 24) begin : g_w24
        assign w_fb = r_rnd[23] ^ r_rnd[22] ^ r_rnd[21] ^ r_rnd[16];
    end else if (WIDTH == 32) begin : g_w32
        assign w_fb = r_rnd[31] ^ r_rnd[21] ^ r_rnd[1] ^ r_rnd[0];
    end else begin : g_bad_width
        $error("lfsr_rng: WIDTH must be 8, 16, 24 or 32");
        assign w_fb = 1'b0;
    end

    // Zero state is unreachable by stepping, so seeing it means corruption.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rnd      <= c_seed_eff;
            r_lock_err <= 1'b0;
        end else begin
            r_lock_err <= 1'b0;
            if (r_rnd == '0) begin
                r_rnd      <= c_seed_eff;
                r_lock_err <= 1'b1;
            end else if (seed_load) begin
                r_rnd <= (seed_in == '0) ? c_seed_eff : seed_in;
            end else if (en || (r_state == c_st_draw)) begin
                r_rnd <= {r_rnd[WIDTH-2:0], w_fb};
            end
        end
    end

    // Smear R-1 rightwards to get the smallest all-ones mask covering it.
    always_comb begin
        w_mask_new = req_range - OUT_W'(1);
        for (int i = 0; i < OUT_W; i++) begin
            w_mask_new = w_mask_new | (w_mask_new >> 1);
        end
    end

    assign w_cand = r_rnd[OUT_W-1:0] & r_mask;
    assign w_hit  = (r_range == '0) || (w_cand < r_range);
    assign w_last = (r_try == c_try_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (req_valid)        w_state_nxt = c_st_draw;
            c_st_draw: if (w_hit || w_last)  w_state_nxt = c_st_done;
            c_st_done: if (resp_ready)       w_state_nxt = c_st_idle;
            default:                         w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == c_st_idle);
        resp_valid = (r_state == c_st_done);
        resp_data  = r_resp_data;
        rnd        = r_rnd;
        lock_err   = r_lock_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_range     <= '0;
            r_mask      <= '0;
            r_try       <= '0;
            r_resp_data <= '0;
        end else begin
            if ((r_state == c_st_idle) && req_valid) begin
                r_range <= req_range;
                r_mask  <= w_mask_new;
                r_try   <= '0;
            end else if (r_state == c_st_draw) begin
                if (w_hit) begin
                    r_resp_data <= w_cand;
                end else if (w_last) begin
                    // mask < 2R, so cand-R always lands inside [0, R-1]
                    r_resp_data <= w_cand - r_range;
                end else begin
                    r_try <= r_try + c_try_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
